// File: rtl/xc_rf_fwd_sb_pkg.sv
// Shared definitions for the forwarding register file: default geometry and
// the operand-source tag reported on the debug outputs.
package xc_rf_fwd_sb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NFWD_DEF  = 2;

    // Where the operand presented on a read port came from this cycle.
    typedef enum logic [1:0] {
        SRC_STORAGE = 2'd0,
        SRC_RD      = 2'd1,
        SRC_FWD     = 2'd2,
        SRC_ZERO    = 2'd3
    } src_e;

    // Low bit of packed field idx when fields are w bits wide.
    function automatic int fld_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/xc_rf_fwd_sb_if.sv
// Bus between decode/issue/writeback and the forwarding register file.
// Strobes (fwd_wen, iss_valid, rd_wen, flush) are level qualifiers sampled on the
// rising edge; there is no back-pressure, so rsX_ready is advisory to issue only.
interface xc_rf_fwd_sb_if
    import xc_rf_fwd_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NFWD  = NFWD_DEF
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]        rs1_addr;
    logic [XLEN-1:0]      rs1_rdata;
    logic                 rs1_ready;
    logic [AW-1:0]        rs2_addr;
    logic [XLEN-1:0]      rs2_rdata;
    logic                 rs2_ready;
    logic [NFWD-1:0]      fwd_wen;
    logic [NFWD-1:0]      fwd_dvalid;
    logic [NFWD*AW-1:0]   fwd_addr;
    logic [NFWD*XLEN-1:0] fwd_wdata;
    logic                 iss_valid;
    logic [AW-1:0]        iss_addr;
    logic                 rd_wen;
    logic [AW-1:0]        rd_addr;
    logic [XLEN-1:0]      rd_wdata;
    logic                 flush;

    modport master (
        output rs1_addr, rs2_addr, fwd_wen, fwd_dvalid, fwd_addr, fwd_wdata,
        output iss_valid, iss_addr, rd_wen, rd_addr, rd_wdata, flush,
        input  rs1_rdata, rs1_ready, rs2_rdata, rs2_ready
    );

    modport slave (
        input  rs1_addr, rs2_addr, fwd_wen, fwd_dvalid, fwd_addr, fwd_wdata,
        input  iss_valid, iss_addr, rd_wen, rd_addr, rd_wdata, flush,
        output rs1_rdata, rs1_ready, rs2_rdata, rs2_ready
    );

endinterface

// File: rtl/xc_rf_storage.sv
// NREGS x XLEN architectural storage: two asynchronous read ports, one write
// port, asynchronous clear; register 0 is never written and always reads 0.
module xc_rf_storage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr0,
    output logic [XLEN-1:0] o_rdata0,
    input  logic [AW-1:0]   i_raddr1,
    output logic [XLEN-1:0] o_rdata1
);

    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = (i_raddr0 == '0) ? '0 : r_mem[i_raddr0];
    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];

endmodule

// File: rtl/xc_rf_fwd_sb.sv
// 2R/1W GPR file with NFWD prioritised forwarding stages and a per-register busy
// scoreboard; each read port reports whether its operand is final.
module xc_rf_fwd_sb
    import xc_rf_fwd_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NFWD  = NFWD_DEF
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    xc_rf_fwd_sb_if.slave    bus,
    output logic [NREGS-1:0] o_busy,
    output src_e             o_rs1_src,
    output src_e             o_rs2_src
);

    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [XLEN-1:0]  w_sto_rdata0;
    logic [XLEN-1:0]  w_sto_rdata1;

    xc_rf_storage #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_storage (
        .i_clk    (i_clock),
        .i_rst_n  (i_resetn),
        .i_we     (bus.rd_wen),
        .i_waddr  (bus.rd_addr),
        .i_wdata  (bus.rd_wdata),
        .i_raddr0 (bus.rs1_addr),
        .o_rdata0 (w_sto_rdata0),
        .i_raddr1 (bus.rs2_addr),
        .o_rdata1 (w_sto_rdata1)
    );

    // Flush wins over everything; otherwise a new producer's set beats a writeback's clear.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.flush) begin
            w_busy_nxt = '0;
        end else begin
            if (bus.rd_wen) begin
                w_busy_nxt[bus.rd_addr] = 1'b0;
            end
            if (bus.iss_valid) begin
                w_busy_nxt[bus.iss_addr] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy = r_busy;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_sto;
        logic [XLEN-1:0] w_rdata;
        logic            w_ready;
        src_e            w_src;

        assign w_addr = (p == 0) ? bus.rs1_addr : bus.rs2_addr;
        assign w_sto  = (p == 0) ? w_sto_rdata0 : w_sto_rdata1;

        // Walk from the lowest-priority source upward so the youngest hit overrides.
        always_comb begin
            w_rdata = w_sto;
            w_ready = ~r_busy[w_addr];
            w_src   = SRC_STORAGE;
            if (bus.rd_wen && (bus.rd_addr == w_addr)) begin
                w_rdata = bus.rd_wdata;
                w_ready = 1'b1;
                w_src   = SRC_RD;
            end
            for (int i = NFWD - 1; i >= 0; i--) begin
                if (bus.fwd_wen[i] && (bus.fwd_addr[fld_lo(i, AW) +: AW] == w_addr)) begin
                    w_rdata = bus.fwd_wdata[fld_lo(i, XLEN) +: XLEN];
                    w_ready = bus.fwd_dvalid[i];
                    w_src   = SRC_FWD;
                end
            end
            if (w_addr == '0) begin
                w_rdata = '0;
                w_ready = 1'b1;
                w_src   = SRC_ZERO;
            end
        end

        if (p == 0) begin : g_out
            assign bus.rs1_rdata = w_rdata;
            assign bus.rs1_ready = w_ready;
            assign o_rs1_src     = w_src;
        end else begin : g_out
            assign bus.rs2_rdata = w_rdata;
            assign bus.rs2_ready = w_ready;
            assign o_rs2_src     = w_src;
        end
    end

endmodule
